// File: rtl/pipe_addsub_if.sv
// -----------------------------------------------------------------------------
// pipe_addsub_if
//   Bundles the operand-side and result-side valid/ready handshakes of
//   pipe_addsub into one interface.
//
//   Signals
//     in_valid   operand beat offered              (master -> slave)
//     in_ready   slave accepts a beat this cycle   (slave  -> master)
//     A, B       operands, DATA_WIDTH bits         (master -> slave)
//     sub        0: A+B, 1: A-B                    (master -> slave)
//     out_valid  result beat valid                 (slave  -> master)
//     out_ready  downstream accepts the result     (master -> slave)
//     S_out      {carry, sum}, DATA_WIDTH+1 bits   (slave  -> master)
//     ovf        signed overflow of the sum        (slave  -> master)
//
//   Modports
//     master  the side that sources operands and sinks results
//     slave   the adder itself
// -----------------------------------------------------------------------------
interface pipe_addsub_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH:0]   S_out;
  logic                  ovf;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, S_out, ovf
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, S_out, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// -----------------------------------------------------------------------------
// pipe_addsub
//   Pipelined two's-complement adder/subtractor. The DATA_WIDTH-bit add is
//   cut into STAGES carry-ripple segments of SEG = DATA_WIDTH/STAGES bits,
//   one register boundary per segment. Subtraction is A + ~B + 1: B is
//   inverted and the carry-in set on entry to segment 0.
//
//   Parameters
//     DATA_WIDTH  operand width (must be a multiple of STAGES)
//     STAGES      pipeline depth; 1 gives a registered full-width adder
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset; clears every stage and the output
//     bus    pipe_addsub_if.slave: operand/result handshakes, S_out, ovf
//
//   Flow control
//     A single global advance enable moves the whole pipeline, bubbles
//     included: w_adv = !out_valid || out_ready, and in_ready = w_adv while
//     out of reset. A beat accepted on edge n is presented after edge
//     n+STAGES-1.
// -----------------------------------------------------------------------------
module pipe_addsub #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pipe_addsub_if.slave  bus
);

  localparam int SEG = DATA_WIDTH / STAGES;

  // Last-stage view, driven from inside the generate loop.
  logic                  w_last_valid;
  logic                  w_last_carry;
  logic [DATA_WIDTH-1:0] w_last_sum;
  logic                  w_ovf_next;
  logic                  r_ovf;
  logic                  w_adv;

  assign w_adv        = !w_last_valid || bus.out_ready;
  // Gated with rst_n so nothing is offered acceptance while in reset.
  assign bus.in_ready = rst_n && w_adv;

  assign bus.out_valid = w_last_valid;
  assign bus.S_out     = {w_last_carry, w_last_sum};
  assign bus.ovf       = r_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Operand bits still to be consumed when entering this segment.
      localparam int HW = DATA_WIDTH - gi * SEG;

      logic [HW-1:0]          w_a_src;
      logic [HW-1:0]          w_b_src;     // already inverted for sub
      logic                   w_cin;
      logic                   w_valid_src;
      logic [SEG:0]           w_seg;       // {carry-out, segment sum}
      logic [(gi+1)*SEG-1:0]  w_sum_next;

      logic                   r_valid;
      logic                   r_carry;
      logic [(gi+1)*SEG-1:0]  r_sum;       // sum bits produced so far

      if (gi == 0) begin : g_src
        // Entry: invert B and inject carry-in = sub in one place so the
        // subtract flag never has to travel down the pipe on its own.
        assign w_a_src     = bus.A;
        assign w_b_src     = bus.B ^ {DATA_WIDTH{bus.sub}};
        assign w_cin       = bus.sub;
        assign w_valid_src = bus.in_valid;
        assign w_sum_next  = w_seg[SEG-1:0];
      end else begin : g_src
        assign w_a_src     = g_stage[gi-1].g_fwd.r_a_hi;
        assign w_b_src     = g_stage[gi-1].g_fwd.r_b_hi;
        assign w_cin       = g_stage[gi-1].r_carry;
        assign w_valid_src = g_stage[gi-1].r_valid;
        assign w_sum_next  = {w_seg[SEG-1:0], g_stage[gi-1].r_sum};
      end

      // SEG-bit ripple segment; the extra MSB is the carry-out.
      assign w_seg = {1'b0, w_a_src[SEG-1:0]}
                   + {1'b0, w_b_src[SEG-1:0]}
                   + {{SEG{1'b0}}, w_cin};

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_carry <= 1'b0;
          r_sum   <= '0;
        end else if (w_adv) begin
          r_valid <= w_valid_src;
          r_carry <= w_seg[SEG];
          r_sum   <= w_sum_next;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        // Unconsumed upper operand bits ride along with the beat; the
        // registers shrink by SEG bits each stage.
        logic [HW-SEG-1:0] r_a_hi;
        logic [HW-SEG-1:0] r_b_hi;

        always_ff @(posedge clk) begin
          if (!rst_n) begin
            r_a_hi <= '0;
            r_b_hi <= '0;
          end else if (w_adv) begin
            r_a_hi <= w_a_src[HW-1:SEG];
            r_b_hi <= w_b_src[HW-1:SEG];
          end
        end
      end

      if (gi == STAGES - 1) begin : g_last
        // Signed overflow: operands (after B inversion) share a sign and
        // the result sign differs from it.
        assign w_ovf_next   = (w_a_src[HW-1] == w_b_src[HW-1])
                           && (w_seg[SEG-1] != w_a_src[HW-1]);
        assign w_last_valid = r_valid;
        assign w_last_carry = r_carry;
        assign w_last_sum   = r_sum;
      end
    end
  endgenerate

  // Overflow flag is registered alongside the last segment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= w_ovf_next;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipe_addsub
//   Scoreboard bench for pipe_addsub (DATA_WIDTH=16, STAGES=4). Accepted
//   beats push an expected {ovf, carry, sum} computed with plain integer
//   arithmetic; a monitor pops and compares on every output handshake.
//   Directed scenarios cover reset, latency, borrow/overflow corners,
//   streaming, backpressure and reset mid-stream; a random phase follows.
// -----------------------------------------------------------------------------
module tb_pipe_addsub;

  localparam int DW = 16;
  localparam int ST = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_addsub_if #(.DATA_WIDTH(DW)) bus ();

  pipe_addsub #(.DATA_WIDTH(DW), .STAGES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp   = 0;
  int n_err   = 0;
  int pops    = 0;
  int run     = 0;
  int max_run = 0;

  logic [17:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: signed result range decides ovf; for subtract the carry is
  // "no borrow", i.e. A >= B unsigned.
  function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic s);
    int          sa;
    int          sb;
    int          r;
    logic        o;
    logic [16:0] res;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = s ? (sa - sb) : (sa + sb);
    o  = (r > 32767) || (r < -32768);
    if (s) res = {(a >= b), 16'(a - b)};
    else   res = {1'b0, a} + {1'b0, b};
    return {o, res};
  endfunction

  // Monitor / scoreboard
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        run = 0;
      end else begin
        if (bus.out_valid) begin
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got S_out=%0h with nothing outstanding (t=%0t)",
                     bus.S_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("S_out", 32'(bus.S_out), 32'(e[16:0]));
            check("ovf", 32'(bus.ovf), 32'(e[17]));
            pops++;
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.A, bus.B, bus.sub));
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(logic [15:0] a, logic [15:0] b, logic s);
    int   t;
    logic acc;
    t   = 0;
    acc = 1'b0;
    bus.A = a; bus.B = b; bus.sub = s; bus.in_valid = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      align();
      t++;
    end
    repeat (2) align();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          lat;
    int          pops0;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        s0;
    logic [17:0] e0;

    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_S_out", 32'(bus.S_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    align();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_in_ready", 32'(bus.in_ready), 32'd1);
    align();

    // First result and latency
    send(16'hFFFF, 16'h0001, 1'b0);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) lat = k;
    end
    check("latency", 32'(lat), 32'(ST));
    @(negedge clk);
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    align();

    // Borrow, overflow and carry-chain corners, back to back
    send(16'h0005, 16'h0007, 1'b1);
    send(16'h0007, 16'h0005, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'h0001, 1'b1);
    send(16'h0FFF, 16'h0001, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    send(16'h0000, 16'h8000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    drain();

    // Streaming: 8 back-to-back beats, alternating sub
    max_run = 0;
    for (int k = 0; k < 8; k++)
      send(16'($urandom), 16'($urandom), k[0]);
    drain();
    check("stream_run", 32'(max_run), 32'd8);

    // Backpressure: 4 beats in flight, 3-cycle stall, 5th beat offered
    pops0 = pops;
    a0 = 16'($urandom); b0 = 16'($urandom); s0 = 1'b1;
    e0 = model(a0, b0, s0);
    send(a0, b0, s0);
    for (int k = 0; k < 3; k++)
      send(16'($urandom), 16'($urandom), 1'($urandom));
    bus.out_ready = 1'b0;
    ra = 16'($urandom); rb = 16'($urandom);
    bus.A = ra; bus.B = rb; bus.sub = 1'b0; bus.in_valid = 1'b1;
    for (int m = 0; m < 3; m++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      check("stall_S_out", 32'(bus.S_out), 32'(e0[16:0]));
      check("stall_ovf", 32'(bus.ovf), 32'(e0[17]));
      align();
    end
    bus.out_ready = 1'b1;
    send(ra, rb, 1'b0);
    drain();
    check("bp_delivered", 32'(pops - pops0), 32'd5);

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = 16'($urandom);
      bus.B         = 16'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      align();
    end
    drain();

    // Reset mid-operation
    for (int k = 0; k < 6; k++)
      send(16'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    align();
    rst_n = 1'b0;
    align();
    @(negedge clk);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_S_out", 32'(bus.S_out), 32'd0);
    check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    align();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_beat", 32'(bus.out_valid), 32'd0);
      align();
    end
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement adder/subtractor: the sequential successor to the single-cycle ripple adder in the arithmetic library. The DATA_WIDTH-bit operation is split into STAGES equal carry-ripple segments, with one register boundary per segment. The carry is handed from each segment to the next. Operands enter and results leave through valid/ready handshakes. The block sits between bus-side operand staging and downstream accumulation logic, where the flat ripple path no longer meets timing.

## Interface

- DATA_WIDTH, 16, operand width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; segment width SEG = DATA_WIDTH/STAGES. STAGES=1 is legal: a registered full-width adder.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, active-low, synchronous; sampled on the clk rising edge.
- in_valid  input  1  operand beat offered.
- in_ready  output  1  block accepts a beat this cycle.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- S_out  output  DATA_WIDTH+1  {carry, sum}. In subtract mode, MSB = 1 means no borrow.
- ovf  output  1  signed overflow of the DATA_WIDTH-bit result.

## Operation

- **Accept.** A beat is accepted when in_valid && in_ready. A, B and sub are captured together; sub travels with the beat.
- **Subtract.** Subtract is computed as A + ~B + 1. The inverted B and carry-in = sub are applied at stage 0.
- **Segment k (0..STAGES-1).**
  - Adds bits [k*SEG +: SEG] of A and B', plus the carry registered from segment k−1 (stage 0 uses sub).
  - Writes sum bits into the beat's partial-result register and registers its carry-out for segment k+1.
  - Upper operand bits not yet consumed are carried forward unchanged in the stage registers.
- **Last segment.**
  - S_out[DATA_WIDTH] = final carry-out.
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b'_msb is the MSB of B after inversion when sub=1.
- **Stall rule.** The pipeline uses one global enable: adv = !out_valid || out_ready. When adv=0, every stage register, including bubbles, holds.
- **in_ready.** in_ready = adv. This is a combinational path from out_ready to in_ready and is accepted.
- **Per-stage valid.** Each stage has its own valid bit. Bubbles (valid=0) shift through on adv like data. out_valid = valid bit of the last stage.
- **Output hold.** When out_valid=1 && out_ready=0, S_out, ovf and out_valid hold stable until the handshake completes.
- **No combining.** There is no reordering, and no combining of beats across stages.

## Timing

- **Reset** (rst_n=0 at a clk edge):
  - All stage valid bits clear, out_valid=0, S_out=0, ovf=0.
  - In-flight beats are discarded, whatever the stall state.
  - While rst_n=0, in_ready is 0.
  - First acceptance is possible on the first edge with rst_n=1 (in_ready=1 that cycle, because out_valid=0).
- **Latency.** With no stalls, a beat accepted at edge n appears with out_valid=1 after edge n+STAGES-1. The result is available STAGES cycles after in_valid is first presented with in_ready high.
- **Throughput.** Throughput is one beat per cycle while out_ready=1.
- **Stall.** A stall of m cycles delays every in-flight beat by exactly m cycles, and no beat is lost or duplicated.
- **Simultaneous output release and input accept.** Both occur in the same cycle; this is the normal streaming case.
- **Sum wrap-around.**
  - The DATA_WIDTH-bit sum wraps modulo 2^DATA_WIDTH.
  - The carry bit and ovf report the wrap.
  - ovf is meaningful for signed interpretation only; for unsigned results the carry is the indicator.
- **sub sampling.** sub changing between consecutive beats has no effect on beats already accepted.

## Test plan

Parameters for all scenarios: DATA_WIDTH=16, STAGES=4.

- **Reset and first result.** Reset, then one add beat A=0xFFFF, B=0x0001, sub=0, out_ready=1 → S_out=0x1_0000, ovf=0, out_valid high exactly 4 cycles after acceptance, then low.
- **Subtract with borrow.** A=0x0005, B=0x0007, sub=1 → S_out=0x0_FFFE (MSB 0 = borrow), ovf=0. A=0x0007, B=0x0005, sub=1 → S_out=0x1_0002.
- **Signed overflow.** 0x7FFF+0x0001 add → S_out=0x0_8000, ovf=1. 0x8000−0x0001 sub → S_out=0x1_7FFF, ovf=1.
- **Streaming.** 8 back-to-back beats, alternating sub, random operands, out_ready=1 → 8 consecutive out_valid cycles, in order, each matching the reference model; carries cross every segment boundary (e.g. 0x0FFF+0x0001 → 0x0_1000).
- **Backpressure.** Drop out_ready for 3 cycles while 4 beats are in flight → in_ready=0 and S_out/ovf frozen during the stall; all 4 results are delivered in order afterwards, with no loss or duplication.
- **Reset mid-operation.** Assert rst_n=0 for 1 cycle with 3 beats in flight and out_valid=1 → next cycle out_valid=0, S_out=0, ovf=0; no stale beat emerges in the following 4 cycles.
